wb_periph_decoder: RTL
======================

Name: wb_periph_decoder

Overview:
- Single-master Wishbone (classic) address decoder and response multiplexer placed between the CPU data bus and the peripheral slaves (GPIO, UART, timer, ...).
- Latches each request, forwards the strobe to exactly one slave and returns that slave's read data and ack to the master.
- Returns an error response for unmapped addresses and for slaves that do not ack within a bounded number of cycles.

Parameters:
- NS, 4, number of slave ports (1..8).
- SLV_BASE, {32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000}, flattened NS×32 base addresses; slave i uses bits [32*i+31:32*i].
- SLV_MASK, {4{32'hFFFF_F000}}, flattened NS×32 address masks; same slicing as SLV_BASE.
- TIMEOUT, 255, cycles in BUSY without an ack before an error is returned (1..65535).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbm_cyc_i  in  1  master cycle.
- wbm_stb_i  in  1  master strobe.
- wbm_we_i  in  1  master write enable.
- wbm_sel_i  in  4  master byte selects.
- wbm_adr_i  in  32  master byte address.
- wbm_dat_i  in  32  master write data.
- wbm_dat_o  out  32  read data returned to master.
- wbm_ack_o  out  1  normal termination.
- wbm_err_o  out  1  error termination (unmapped address or timeout).
- wbs_adr_o  out  32  latched address, shared by all slaves.
- wbs_dat_o  out  32  latched write data, shared.
- wbs_we_o  out  1  latched write enable, shared.
- wbs_sel_o  out  4  latched byte selects, shared.
- wbs_stb_o  out  NS  per-slave strobe; at most one bit high.
- wbs_dat_i  in  32*NS  flattened slave read data.
- wbs_ack_i  in  NS  per-slave ack.

Behaviour:
- Reset (wb_clk_i edge with wb_rst_i=1): state=IDLE; wbm_ack_o=0; wbm_err_o=0; wbm_dat_o=0; wbs_stb_o=0; wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o=0; timeout counter=0. Reset overrides any in-flight transaction; no ack or err is produced for it.
- Decode: slave i hits when (wbm_adr_i & MASK_i) == (BASE_i & MASK_i). On multiple hits the lowest index wins. No hit means unmapped.
- IDLE: when wbm_cyc_i & wbm_stb_i are both 1, latch adr, dat, we, sel and the decoded index.
  - Hit: go to BUSY.
  - Miss: go to ERR.
- BUSY: wbs_stb_o[idx]=1, all other bits 0; wbs_stb_o is a combinational decode of (state==BUSY, idx). The counter increments each BUSY cycle.
  - wbs_ack_i[idx]=1: register wbs_dat_i slice idx into wbm_dat_o, go to RESP. Acks from non-selected slaves are ignored.
  - Counter reaches TIMEOUT-1 with no ack: go to ERR.
  - wbm_cyc_i=0: abort to IDLE; no ack or err.
- RESP: wbm_ack_o=1 for exactly one cycle, then IDLE.
- ERR: wbm_err_o=1 for exactly one cycle, wbm_dat_o=0, then IDLE.
- ack and err are never asserted together. The counter clears on entry to BUSY.
- Latency with a slave that acks one cycle after strobe (e.g. GPIO): request seen in cycle 0, wbs_stb_o high in cycle 1, slave ack in cycle 2, wbm_ack_o in cycle 3.
- Unmapped access: wbm_err_o in cycle 1.
- Slave strobe drops in the cycle after the slave ack, so slaves that ack on (stb & !ack) see exactly one ack per access.
- Requests are accepted only in IDLE. A master still holding stb in the cycle after ack or err starts a new transaction (back-to-back). Address and data changes outside IDLE have no effect on the latched values.
- Write data is passed through unmodified; byte lane handling is the slave's responsibility.

Test Plan:
- Write: adr=32'h4000_0000, dat=32'h0100_0001, sel=4'hF, we=1 -> wbs_stb_o=4'b0001 in cycle 1; wbs_dat_o=32'h0100_0001; wbm_ack_o in cycle 3; wbm_err_o stays 0.
- Read: slave 2 at adr=32'h4000_2004 drives 32'hDEAD_BEEF and acks one cycle after strobe -> wbs_stb_o=4'b0100; wbm_dat_o=32'hDEAD_BEEF with wbm_ack_o in cycle 3.
- Unmapped: adr=32'h8000_0000 -> wbm_err_o pulses in cycle 1; wbm_dat_o=0; wbs_stb_o remains 0 throughout.
- Timeout: TIMEOUT=8, slave 1 never acks -> wbs_stb_o[1] high for 8 cycles, then a one-cycle wbm_err_o, then IDLE; a following access to slave 0 completes normally.
- Abort and reset: drop wbm_cyc_i in the 2nd BUSY cycle -> IDLE next cycle with no ack or err. Assert wb_rst_i mid-BUSY -> all outputs 0 the following cycle.
- Back-to-back and overlap: stb held across two accesses -> two separate acks with correct data each. Overlapping masks on slaves 0 and 1 -> only slave 0 is strobed.

Source files
------------

// File: rtl/wb_periph_decoder.sv
// Wishbone classic single-master address decoder and response multiplexer.
// One request is latched at a time and forwarded to the single slave whose
// base/mask window matches. The slave's ack and read data are returned to the
// master. Unmapped addresses and slaves that never ack end in an error response.
module wb_periph_decoder #(
    parameter int               NS       = 4,
    parameter logic [32*NS-1:0] SLV_BASE = {32'h4000_3000, 32'h4000_2000,
                                            32'h4000_1000, 32'h4000_0000},
    parameter logic [32*NS-1:0] SLV_MASK = {4{32'hFFFF_F000}},
    parameter int               TIMEOUT  = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    // master side
    input  logic             wbm_cyc_i,
    input  logic             wbm_stb_i,
    input  logic             wbm_we_i,
    input  logic [3:0]       wbm_sel_i,
    input  logic [31:0]      wbm_adr_i,
    input  logic [31:0]      wbm_dat_i,
    output logic [31:0]      wbm_dat_o,
    output logic             wbm_ack_o,
    output logic             wbm_err_o,
    // slave side
    output logic [31:0]      wbs_adr_o,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_we_o,
    output logic [3:0]       wbs_sel_o,
    output logic [NS-1:0]    wbs_stb_o,
    input  logic [32*NS-1:0] wbs_dat_i,
    input  logic [NS-1:0]    wbs_ack_i
);

    localparam int          IW       = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [15:0]   cnt;

    logic          dec_hit;
    logic [IW-1:0] dec_idx;
    logic          sel_ack;
    logic [31:0]   sel_dat;
    logic          req;

    assign req = wbm_cyc_i & wbm_stb_i;

    // Address decode of the live master address; lowest matching index wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((wbm_adr_i & SLV_MASK[32*i +: 32]) ==
                (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    // Select the ack and read data of the latched target; other acks are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NS; i++) begin
            if (idx == IW'(i)) begin
                sel_ack = wbs_ack_i[i];
                sel_dat = wbs_dat_i[32*i +: 32];
            end
        end
    end

    // Next-state logic: accept only in IDLE; abort beats ack, which beats timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = dec_hit ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (!wbm_cyc_i) begin
                    state_nxt = IDLE;
                end else if (sel_ack) begin
                    state_nxt = RESP;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = ERR;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, request latches, wait counter and returned read data.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            wbm_dat_o <= '0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && req) begin
                wbs_adr_o <= wbm_adr_i;
                wbs_dat_o <= wbm_dat_i;
                wbs_we_o  <= wbm_we_i;
                wbs_sel_o <= wbm_sel_i;
                idx       <= dec_idx;
            end

            // Counter is held at zero outside BUSY, so it starts clean on entry.
            if (state == BUSY) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= '0;
            end

            if (state_nxt == ERR) begin
                wbm_dat_o <= '0;
            end else if (state == BUSY && state_nxt == RESP) begin
                wbm_dat_o <= sel_dat;
            end
        end
    end

    // Per-slave strobe is a pure decode of (BUSY, idx).
    always_comb begin
        wbs_stb_o = '0;
        if (state == BUSY) begin
            for (int i = 0; i < NS; i++) begin
                if (idx == IW'(i)) begin
                    wbs_stb_o[i] = 1'b1;
                end
            end
        end
    end

    assign wbm_ack_o = (state == RESP);
    assign wbm_err_o = (state == ERR);

endmodule
